// File: rtl/pipelined_butterfly.sv
// Three-stage radix-2 DIT butterfly: a_o = a + W*b, b_o = a - W*b.
// Stage 1 forms the four partial products, stage 2 rounds and saturates the
// rotated b, stage 3 forms sum/difference with optional halving.
// A single global advance signal stalls every stage together.
module pipelined_butterfly #(
    parameter int DATA_WIDTH = 16,
    parameter int TW_WIDTH   = 16,
    parameter int FRAC_BITS  = 15
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic signed [DATA_WIDTH-1:0] a_re_i,
    input  logic signed [DATA_WIDTH-1:0] a_im_i,
    input  logic signed [DATA_WIDTH-1:0] b_re_i,
    input  logic signed [DATA_WIDTH-1:0] b_im_i,
    input  logic signed [TW_WIDTH-1:0]   tw_re_i,
    input  logic signed [TW_WIDTH-1:0]   tw_im_i,
    input  logic                         inverse_i,
    input  logic                         scale_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic signed [DATA_WIDTH:0]   a_re_o,
    output logic signed [DATA_WIDTH:0]   a_im_o,
    output logic signed [DATA_WIDTH:0]   b_re_o,
    output logic signed [DATA_WIDTH:0]   b_im_o,
    output logic                         ovf_o
);

    localparam int DW = DATA_WIDTH;
    localparam int TW = TW_WIDTH;
    localparam int PW = DATA_WIDTH + TW_WIDTH;
    localparam int RW = PW + 1;
    localparam int OW = DATA_WIDTH + 1;

    localparam logic signed [TW-1:0] TW_MAX  = {1'b0, {(TW-1){1'b1}}};
    localparam logic signed [TW-1:0] TW_MIN  = {1'b1, {(TW-1){1'b0}}};
    localparam logic signed [RW-1:0] RND     = {{(RW-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
    localparam logic signed [RW-1:0] SAT_MAX = {{(RW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [RW-1:0] SAT_MIN = {{(RW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    // Round half toward +inf, then clip to DW bits; returns {saturated, value}.
    function automatic logic [DW:0] round_sat(input logic signed [RW-1:0] rot);
        logic signed [RW-1:0] r;
        r = (rot + RND) >>> FRAC_BITS;
        if (r > SAT_MAX)
            round_sat = {1'b1, SAT_MAX[DW-1:0]};
        else if (r < SAT_MIN)
            round_sat = {1'b1, SAT_MIN[DW-1:0]};
        else
            round_sat = {1'b0, r[DW-1:0]};
    endfunction

    // (x + 1) >>> 1 without a wider intermediate: x>>>1 plus the dropped LSB.
    function automatic logic [OW-1:0] halve(input logic [OW-1:0] x, input logic en);
        if (en)
            halve = {x[OW-1], x[OW-1:1]} + {{(OW-1){1'b0}}, x[0]};
        else
            halve = x;
    endfunction

    logic advance;
    assign advance    = out_ready_i || !out_valid_o;
    assign in_ready_o = advance;

    // Conjugate for the inverse transform; -MIN would wrap, so clamp to +MAX.
    logic signed [TW-1:0] tw_im_eff;
    always_comb begin
        tw_im_eff = tw_im_i;
        if (inverse_i)
            tw_im_eff = (tw_im_i == TW_MIN) ? TW_MAX : -tw_im_i;
    end

    logic                 s1_valid, s1_scale;
    logic signed [PW-1:0] s1_rr, s1_ii, s1_ri, s1_ir;
    logic signed [DW-1:0] s1_a_re, s1_a_im;

    // Stage 1: full-precision partial products of b and the effective twiddle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_scale <= 1'b0;
            s1_rr    <= '0;
            s1_ii    <= '0;
            s1_ri    <= '0;
            s1_ir    <= '0;
            s1_a_re  <= '0;
            s1_a_im  <= '0;
        end else if (advance) begin
            s1_valid <= in_valid_i;
            s1_scale <= scale_i;
            s1_rr    <= PW'(b_re_i) * PW'(tw_re_i);
            s1_ii    <= PW'(b_im_i) * PW'(tw_im_eff);
            s1_ri    <= PW'(b_re_i) * PW'(tw_im_eff);
            s1_ir    <= PW'(b_im_i) * PW'(tw_re_i);
            s1_a_re  <= a_re_i;
            s1_a_im  <= a_im_i;
        end
    end

    logic signed [RW-1:0] rot_re, rot_im;
    logic        [DW:0]   sat_re, sat_im;
    assign rot_re = RW'(s1_rr) - RW'(s1_ii);
    assign rot_im = RW'(s1_ri) + RW'(s1_ir);
    assign sat_re = round_sat(rot_re);
    assign sat_im = round_sat(rot_im);

    logic                 s2_valid, s2_scale, s2_ovf;
    logic signed [DW-1:0] s2_b_re, s2_b_im, s2_a_re, s2_a_im;

    // Stage 2: rounded, saturated rotation of b plus its overflow flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s2_valid <= 1'b0;
            s2_scale <= 1'b0;
            s2_ovf   <= 1'b0;
            s2_b_re  <= '0;
            s2_b_im  <= '0;
            s2_a_re  <= '0;
            s2_a_im  <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            s2_scale <= s1_scale;
            s2_ovf   <= sat_re[DW] | sat_im[DW];
            s2_b_re  <= sat_re[DW-1:0];
            s2_b_im  <= sat_im[DW-1:0];
            s2_a_re  <= s1_a_re;
            s2_a_im  <= s1_a_im;
        end
    end

    logic [OW-1:0] sum_re, sum_im, dif_re, dif_im;
    assign sum_re = {s2_a_re[DW-1], s2_a_re} + {s2_b_re[DW-1], s2_b_re};
    assign sum_im = {s2_a_im[DW-1], s2_a_im} + {s2_b_im[DW-1], s2_b_im};
    assign dif_re = {s2_a_re[DW-1], s2_a_re} - {s2_b_re[DW-1], s2_b_re};
    assign dif_im = {s2_a_im[DW-1], s2_a_im} - {s2_b_im[DW-1], s2_b_im};

    // Stage 3: butterfly sum/difference, optionally halved, into the outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            ovf_o       <= 1'b0;
            a_re_o      <= '0;
            a_im_o      <= '0;
            b_re_o      <= '0;
            b_im_o      <= '0;
        end else if (advance) begin
            out_valid_o <= s2_valid;
            ovf_o       <= s2_ovf;
            a_re_o      <= halve(sum_re, s2_scale);
            a_im_o      <= halve(sum_im, s2_scale);
            b_re_o      <= halve(dif_re, s2_scale);
            b_im_o      <= halve(dif_im, s2_scale);
        end
    end

endmodule

// File: tb/tb_pipelined_butterfly.sv
// Directed bench for pipelined_butterfly: hand-computed vectors, a random
// backpressure stream checked against an integer reference, and mid-stream reset.
module tb_pipelined_butterfly;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic signed [15:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0, tw_re = '0, tw_im = '0;
    logic inverse = 1'b0, scale = 1'b0;
    logic signed [16:0] a_re_o, a_im_o, b_re_o, b_im_o;
    logic ovf;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipelined_butterfly #(.DATA_WIDTH(16), .TW_WIDTH(16), .FRAC_BITS(15)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .a_re_i(a_re), .a_im_i(a_im), .b_re_i(b_re), .b_im_i(b_im),
        .tw_re_i(tw_re), .tw_im_i(tw_im),
        .inverse_i(inverse), .scale_i(scale),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .a_re_o(a_re_o), .a_im_o(a_im_o), .b_re_o(b_re_o), .b_im_o(b_im_o),
        .ovf_o(ovf)
    );

    wire [68:0] outs = {a_re_o, a_im_o, b_re_o, b_im_o, ovf};

    task automatic drive(input int ar, ai, br, bi, wr, wi, input logic inv, sc);
        a_re = 16'(ar); a_im = 16'(ai); b_re = 16'(br); b_im = 16'(bi);
        tw_re = 16'(wr); tw_im = 16'(wi); inverse = inv; scale = sc;
    endtask

    // One beat with no backpressure; lat = edges until out_valid, -1 on timeout.
    task automatic send_and_wait(input int ar, ai, br, bi, wr, wi, input logic inv, sc,
                                 output int lat);
        @(posedge clk); #1;
        out_ready = 1'b1;
        drive(ar, ai, br, bi, wr, wi, inv, sc);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1;
        for (int n = 1; n <= 8; n++) begin
            if (out_valid) begin
                lat = n;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [68:0] ref_model(input int ar, ai, br, bi, wr, wi,
                                              input logic inv, sc);
        longint w_im, xr, xi, rr, ri, sr, si, dr, di;
        logic o;
        w_im = inv ? ((wi == -32768) ? 32767 : -wi) : wi;
        xr = longint'(br) * wr - longint'(bi) * w_im;
        xi = longint'(br) * w_im + longint'(bi) * wr;
        rr = (xr + 16384) >>> 15;
        ri = (xi + 16384) >>> 15;
        o = 1'b0;
        if (rr > 32767)  begin rr = 32767;  o = 1'b1; end
        if (rr < -32768) begin rr = -32768; o = 1'b1; end
        if (ri > 32767)  begin ri = 32767;  o = 1'b1; end
        if (ri < -32768) begin ri = -32768; o = 1'b1; end
        sr = ar + rr; si = ai + ri; dr = ar - rr; di = ai - ri;
        if (sc) begin
            sr = (sr + 1) >>> 1; si = (si + 1) >>> 1;
            dr = (dr + 1) >>> 1; di = (di + 1) >>> 1;
        end
        return {17'(sr), 17'(si), 17'(dr), 17'(di), o};
    endfunction

    task automatic test_reset();
        @(posedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: out_valid=%b expected 0", out_valid);
        end
        n_tests++;
        if (outs !== 69'd0) begin
            n_fail++; $display("FAIL reset_data: outputs=%h expected 0", outs);
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: in_ready=%b expected 1", in_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_identity();
        int lat;
        send_and_wait(1000, 0, 2000, 0, 32767, 0, 1'b0, 1'b0, lat);
        n_tests++;
        if (lat !== 3) begin
            n_fail++; $display("FAIL identity_latency: got %0d expected 3", lat);
        end
        n_tests++;
        if (outs !== {17'sd3000, 17'sd0, -17'sd1000, 17'sd0, 1'b0}) begin
            n_fail++;
            $display("FAIL identity: got a=(%0d,%0d) b=(%0d,%0d) ovf=%b expected a=(3000,0) b=(-1000,0) ovf=0",
                     a_re_o, a_im_o, b_re_o, b_im_o, ovf);
        end
    endtask

    task automatic test_twiddle_inverse();
        int lat;
        send_and_wait(1000, 0, 2000, 0, 0, -32768, 1'b0, 1'b0, lat);
        n_tests++;
        if (lat !== 3 || outs !== {17'sd1000, -17'sd2000, 17'sd1000, 17'sd2000, 1'b0}) begin
            n_fail++;
            $display("FAIL twiddle_fwd: lat=%0d a=(%0d,%0d) b=(%0d,%0d) ovf=%b expected lat=3 a=(1000,-2000) b=(1000,2000) ovf=0",
                     lat, a_re_o, a_im_o, b_re_o, b_im_o, ovf);
        end
        send_and_wait(1000, 0, 2000, 0, 0, -32768, 1'b1, 1'b0, lat);
        n_tests++;
        if (lat !== 3 || outs !== {17'sd1000, 17'sd2000, 17'sd1000, -17'sd2000, 1'b0}) begin
            n_fail++;
            $display("FAIL twiddle_inv: lat=%0d a=(%0d,%0d) b=(%0d,%0d) ovf=%b expected lat=3 a=(1000,2000) b=(1000,-2000) ovf=0",
                     lat, a_re_o, a_im_o, b_re_o, b_im_o, ovf);
        end
    endtask

    task automatic test_saturation();
        int lat;
        send_and_wait(0, 0, -32768, 0, -32768, 0, 1'b0, 1'b0, lat);
        n_tests++;
        if (lat !== 3 || outs !== {17'sd32767, 17'sd0, -17'sd32767, 17'sd0, 1'b1}) begin
            n_fail++;
            $display("FAIL saturation: lat=%0d a=(%0d,%0d) b=(%0d,%0d) ovf=%b expected lat=3 a=(32767,0) b=(-32767,0) ovf=1",
                     lat, a_re_o, a_im_o, b_re_o, b_im_o, ovf);
        end
        send_and_wait(0, 0, 100, 0, 32767, 0, 1'b0, 1'b0, lat);
        n_tests++;
        if (lat !== 3 || outs !== {17'sd100, 17'sd0, -17'sd100, 17'sd0, 1'b0}) begin
            n_fail++;
            $display("FAIL saturation_next: lat=%0d a=(%0d,%0d) b=(%0d,%0d) ovf=%b expected lat=3 a=(100,0) b=(-100,0) ovf=0",
                     lat, a_re_o, a_im_o, b_re_o, b_im_o, ovf);
        end
    endtask

    task automatic test_back_to_back_scaling();
        int lat;
        @(posedge clk); #1;
        out_ready = 1'b1;
        drive(3, -3, 0, 0, 32767, 0, 1'b0, 1'b1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        drive(3, -3, 0, 0, 32767, 0, 1'b0, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1;
        for (int n = 2; n <= 8; n++) begin
            if (out_valid) begin
                lat = n;
                break;
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (lat !== 3 || outs !== {17'sd2, -17'sd1, 17'sd2, -17'sd1, 1'b0}) begin
            n_fail++;
            $display("FAIL scale_on: lat=%0d a=(%0d,%0d) b=(%0d,%0d) expected lat=3 a=(2,-1) b=(2,-1)",
                     lat, a_re_o, a_im_o, b_re_o, b_im_o);
        end
        @(posedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b1 || outs !== {17'sd3, -17'sd3, 17'sd3, -17'sd3, 1'b0}) begin
            n_fail++;
            $display("FAIL scale_off: valid=%b a=(%0d,%0d) b=(%0d,%0d) expected valid=1 a=(3,-3) b=(3,-3)",
                     out_valid, a_re_o, a_im_o, b_re_o, b_im_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int vin[10][6];
        logic vinv[10], vsc[10];
        logic [68:0] expv[10];
        logic [68:0] held;
        int tx, rx;
        logic stall_prev;
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < 6; k++) vin[i][k] = int'($urandom_range(65535)) - 32768;
            vinv[i] = 1'(i % 2);
            vsc[i]  = 1'((i / 2) % 2);
            expv[i] = ref_model(vin[i][0], vin[i][1], vin[i][2], vin[i][3], vin[i][4], vin[i][5],
                                vinv[i], vsc[i]);
        end
        tx = 0; rx = 0; stall_prev = 1'b0; held = '0;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 300 && rx < 10; cyc++) begin
            if (stall_prev) begin
                n_tests++;
                if (out_valid !== 1'b1 || outs !== held) begin
                    n_fail++;
                    $display("FAIL bp_hold: valid=%b outputs=%h expected valid=1 outputs=%h",
                             out_valid, outs, held);
                end
            end
            out_ready = 1'($urandom_range(1));
            if (tx < 10) begin
                drive(vin[tx][0], vin[tx][1], vin[tx][2], vin[tx][3], vin[tx][4], vin[tx][5],
                      vinv[tx], vsc[tx]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            n_tests++;
            if (in_ready !== (out_ready || !out_valid)) begin
                n_fail++;
                $display("FAIL bp_ready: in_ready=%b expected %b", in_ready, out_ready || !out_valid);
            end
            if (out_valid && out_ready) begin
                n_tests++;
                if (outs !== expv[rx]) begin
                    n_fail++;
                    $display("FAIL bp_data[%0d]: got %h expected %h", rx, outs, expv[rx]);
                end
                rx++;
            end
            if (in_valid && in_ready) tx++;
            stall_prev = out_valid && !out_ready;
            held = outs;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_tests++;
        if (rx !== 10) begin
            n_fail++; $display("FAIL bp_count: received %0d beats expected 10", rx);
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        int lat, extra;
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(1000, 0, 2000, 0, 32767, 0, 1'b0, 1'b0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        drive(5, 5, 5, 5, 32767, 0, 1'b0, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_pre: out_valid=%b expected 1", out_valid);
        end
        #3;
        rst = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || outs !== 69'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid: valid=%b outputs=%h in_ready=%b expected valid=0 outputs=0 in_ready=1",
                     out_valid, outs, in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        send_and_wait(0, 0, 2000, 0, 0, -32768, 1'b0, 1'b0, lat);
        n_tests++;
        if (lat !== 3 || outs !== {17'sd0, -17'sd2000, 17'sd0, 17'sd2000, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_mid_after: lat=%0d a=(%0d,%0d) b=(%0d,%0d) expected lat=3 a=(0,-2000) b=(0,2000)",
                     lat, a_re_o, a_im_o, b_re_o, b_im_o);
        end
        extra = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (out_valid) extra++;
        end
        n_tests++;
        if (extra !== 0) begin
            n_fail++; $display("FAIL rst_mid_stale: %0d extra valid cycles expected 0", extra);
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_twiddle_inverse();
        test_saturation();
        test_back_to_back_scaling();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
